// File: rtl/pt2262_pkg.sv
// Shared types and constants for the PT2262 transmit scheduler.
package pt2262_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_FRAME_REPEAT = 4;
  localparam int A_W              = 8;
  localparam int D_W              = 4;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pt2262_rr_arbiter.sv
// Combinational round-robin search: first asserted req at or after ptr wins.
module pt2262_rr_arbiter
  import pt2262_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  always_comb begin : p_search
    int idx;
    logic [PTR_W-1:0] idx_s;
    idx    = 0;
    idx_s  = '0;
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx   = (int'(ptr) + i) % N_REQ;
      idx_s = PTR_W'(idx);
      if (!valid && req[idx_s]) begin
        winner[idx_s] = 1'b1;
        valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pt2262_tx_scheduler.sv
// Round-robin scheduler sharing one PT2262 encoder among N_REQ requesters.
// Optional sync watchdog is compiled in with PT2262_SCHED_TIMEOUT_EN.
module pt2262_tx_scheduler
  import pt2262_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int FRAME_REPEAT   = DEF_FRAME_REPEAT,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [A_W*N_REQ-1:0]   a_in,
  input  logic [D_W*N_REQ-1:0]   d_in,
  input  logic                   sync,
  output logic [A_W-1:0]         enc_a,
  output logic [D_W-1:0]         enc_d,
  output logic                   enc_en,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   err,
  output state_t                 fsm_state
);

  localparam int PTR_W = clog2_min1(N_REQ);
  localparam int FC_W  = clog2_min1(FRAME_REPEAT + 1);

  state_t             state, state_next;
  logic               sync_q;
  logic [FC_W-1:0]    frame_cnt;
  logic [PTR_W-1:0]   ptr, win_idx, arb_idx;
  logic [N_REQ-1:0]   arb_onehot;
  logic               arb_valid;
  logic [A_W-1:0]     a_sel;
  logic [D_W-1:0]     d_sel;
  logic               sync_edge, last_frame, grant_now, finish_ok, timeout, wd_expired;
  logic [N_REQ-1:0]   gnt_next, done_next;
  logic               enc_en_next, busy_next, err_next;

  pt2262_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (arb_onehot),
    .valid  (arb_valid)
  );

  assign sync_edge  = sync & ~sync_q;
  assign last_frame = (frame_cnt == FC_W'(FRAME_REPEAT - 1));
  assign grant_now  = (state == ST_IDLE) && arb_valid;
  assign finish_ok  = (state == ST_SEND) && sync_edge && last_frame;
  assign timeout    = (state == ST_SEND) && wd_expired && !finish_ok;
  assign fsm_state  = state;

  always_comb begin
    arb_idx = '0;
    a_sel   = '0;
    d_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_onehot[i]) begin
        arb_idx = PTR_W'(i);
        a_sel   = a_in[i*A_W +: A_W];
        d_sel   = d_in[i*D_W +: D_W];
      end
    end
  end

`ifdef PT2262_SCHED_TIMEOUT_EN
  localparam int WD_W = clog2_min1(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset || grant_now || sync_edge) wd_cnt <= '0;
    else if (state == ST_SEND)           wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) && !sync_edge;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sync_q    <= 1'b0;
      frame_cnt <= '0;
      ptr       <= '0;
      win_idx   <= '0;
      enc_a     <= '0;
      enc_d     <= '0;
      enc_en    <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state  <= state_next;
      sync_q <= sync;
      enc_en <= enc_en_next;
      gnt    <= gnt_next;
      done   <= done_next;
      busy   <= busy_next;
      err    <= err_next;
      if (grant_now) begin
        win_idx <= arb_idx;
        enc_a   <= a_sel;
        enc_d   <= d_sel;
      end
      if (state == ST_DONE) begin
        frame_cnt <= '0;
        ptr       <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if ((state == ST_SEND) && sync_edge) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (arb_valid) state_next = ST_SEND;
      ST_SEND: if (finish_ok || timeout) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Grant and enable hold through SEND and drop together on the way to DONE.
  always_comb begin
    gnt_next    = gnt;
    enc_en_next = enc_en;
    if (grant_now) begin
      gnt_next    = arb_onehot;
      enc_en_next = 1'b1;
    end else if (state_next != ST_SEND) begin
      gnt_next    = '0;
      enc_en_next = 1'b0;
    end
    done_next = finish_ok ? gnt : '0;
    busy_next = (state_next != ST_IDLE);
    err_next  = timeout;
  end

endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// Directed bench for pt2262_tx_scheduler; a second instance covers FRAME_REPEAT=1.
module tb_pt2262_tx_scheduler;
  import pt2262_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [15:0] d_in;
  logic        sync;
  logic [7:0]  enc_a;
  logic [3:0]  enc_d;
  logic        enc_en, busy, err;
  logic [3:0]  gnt, done;
  state_t      st;

  logic [1:0]  req1;
  logic [15:0] a1;
  logic [7:0]  d1;
  logic        sync1;
  logic [7:0]  enc_a1;
  logic [3:0]  enc_d1;
  logic        enc_en1, busy1, err1;
  logic [1:0]  gnt1, done1;
  state_t      st1;

  int n_cmp = 0;
  int n_bad = 0;

  wire [12:0] obs  = {st, busy, enc_en, err, gnt, done};
  wire [8:0]  obs1 = {st1, busy1, enc_en1, err1, gnt1, done1};

  always #5 clk = ~clk;

  pt2262_tx_scheduler #(.N_REQ(4), .FRAME_REPEAT(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .d_in(d_in), .sync(sync),
    .enc_a(enc_a), .enc_d(enc_d), .enc_en(enc_en), .gnt(gnt), .done(done),
    .busy(busy), .err(err), .fsm_state(st)
  );

  pt2262_tx_scheduler #(.N_REQ(2), .FRAME_REPEAT(1), .TIMEOUT_CYCLES(100)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .a_in(a1), .d_in(d1), .sync(sync1),
    .enc_a(enc_a1), .enc_d(enc_d1), .enc_en(enc_en1), .gnt(gnt1), .done(done1),
    .busy(busy1), .err(err1), .fsm_state(st1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; a_in = '0; d_in = '0; sync = 1'b0;
    req1 = '0; a1 = '0; d1 = '0; sync1 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if (obs !== {ST_IDLE, 3'b000, 8'h00}) begin
      n_bad++; $display("FAIL reset_ctrl: got %h want %h", obs, {ST_IDLE, 3'b000, 8'h00});
    end
    n_cmp++;
    if ({enc_a, enc_d} !== 12'h000) begin
      n_bad++; $display("FAIL reset_data: got %h want 000", {enc_a, enc_d});
    end
    n_cmp++;
    if (obs1 !== {ST_IDLE, 3'b000, 4'h0}) begin
      n_bad++; $display("FAIL reset_ctrl1: got %h want %h", obs1, {ST_IDLE, 3'b000, 4'h0});
    end
  endtask

  task automatic test_basic();
    a_in = 32'h0000_00A5; d_in = 16'h0003; req = 4'b0001;
    tick();
    n_cmp++;
    if (obs !== {ST_SEND, 3'b110, 4'b0001, 4'b0000}) begin
      n_bad++; $display("FAIL basic_grant: got %h want %h", obs, {ST_SEND, 3'b110, 4'b0001, 4'b0000});
    end
    a_in = 32'h0000_005A; d_in = 16'h000C;
    for (int f = 0; f < 4; f++) begin
      sync = 1'b1;
      tick();
      n_cmp++;
      if ({enc_a, enc_d} !== 12'hA53) begin
        n_bad++; $display("FAIL basic_latch f%0d: got %h want a53", f, {enc_a, enc_d});
      end
      if (f < 3) begin
        n_cmp++;
        if (obs !== {ST_SEND, 3'b110, 4'b0001, 4'b0000}) begin
          n_bad++; $display("FAIL basic_send f%0d: got %h want %h", f, obs, {ST_SEND, 3'b110, 4'b0001, 4'b0000});
        end
      end else begin
        req = 4'b0000;
        n_cmp++;
        if (obs !== {ST_DONE, 3'b100, 4'b0000, 4'b0001}) begin
          n_bad++; $display("FAIL basic_done: got %h want %h", obs, {ST_DONE, 3'b100, 4'b0000, 4'b0001});
        end
      end
      sync = 1'b0;
      tick();
    end
    n_cmp++;
    if (obs !== {ST_IDLE, 3'b000, 8'h00}) begin
      n_bad++; $display("FAIL basic_idle: got %h want %h", obs, {ST_IDLE, 3'b000, 8'h00});
    end
  endtask

  task automatic run_burst(input logic [3:0] r, input logic [3:0] g, input logic [11:0] ad,
                           input string name, input bit drop);
    logic [12:0] e_send, e_done, e_idle;
    e_send = {ST_SEND, 3'b110, g, 4'b0000};
    e_done = {ST_DONE, 3'b100, 4'b0000, g};
    e_idle = {ST_IDLE, 3'b000, 8'h00};
    req = r;
    tick();
    n_cmp++;
    if (obs !== e_send || {enc_a, enc_d} !== ad) begin
      n_bad++; $display("FAIL %s_grant: got %h/%h want %h/%h", name, obs, {enc_a, enc_d}, e_send, ad);
    end
    for (int f = 0; f < 4; f++) begin
      sync = 1'b1;
      tick();
      if (drop && f == 0) req = 4'b0000;
      n_cmp++;
      if (f < 3 && obs !== e_send) begin
        n_bad++; $display("FAIL %s_send f%0d: got %h want %h", name, f, obs, e_send);
      end else if (f == 3 && obs !== e_done) begin
        n_bad++; $display("FAIL %s_done: got %h want %h", name, obs, e_done);
      end
      sync = 1'b0;
      tick();
    end
    n_cmp++;
    if (obs !== e_idle) begin
      n_bad++; $display("FAIL %s_idle: got %h want %h", name, obs, e_idle);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ea;
    logic [3:0] ed;
    reset = 1'b1; tick(); reset = 1'b0;
    a_in = 32'h4433_2211; d_in = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      ea = 8'h11 * 8'((k % 4) + 1);
      ed = 4'((k % 4) + 1);
      run_burst(4'b1111, 4'b0001 << (k % 4), {ea, ed}, "rr", 1'b0);
    end
    req = 4'b0000;
  endtask

  task automatic test_drop();
    run_burst(4'b0010, 4'b0010, {8'h22, 4'h2}, "pre_drop", 1'b0);
    req = 4'b0000;
    run_burst(4'b0100, 4'b0100, {8'h33, 4'h3}, "drop", 1'b1);
  endtask

  task automatic test_reset_mid();
    req = 4'b1001;
    tick();
    n_cmp++;
    if (obs !== {ST_SEND, 3'b110, 4'b1000, 4'b0000}) begin
      n_bad++; $display("FAIL ptr_wrap_grant: got %h want %h", obs, {ST_SEND, 3'b110, 4'b1000, 4'b0000});
    end
    for (int f = 0; f < 2; f++) begin
      sync = 1'b1; tick(); sync = 1'b0; tick();
    end
    reset = 1'b1; sync = 1'b1;
    tick();
    reset = 1'b0; sync = 1'b0;
    n_cmp++;
    if (obs !== {ST_IDLE, 3'b000, 8'h00} || {enc_a, enc_d} !== 12'h000) begin
      n_bad++; $display("FAIL midreset_out: got %h/%h want %h/000", obs, {enc_a, enc_d}, {ST_IDLE, 3'b000, 8'h00});
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (obs !== {ST_IDLE, 3'b000, 8'h00}) begin
      n_bad++; $display("FAIL midreset_nodone: got %h want %h", obs, {ST_IDLE, 3'b000, 8'h00});
    end
    run_burst(4'b1001, 4'b0001, {8'h11, 4'h1}, "post_reset", 1'b0);
    req = 4'b0000;
  endtask

  task automatic test_frame1();
    a1 = 16'hC33C; d1 = 8'h96;
    sync1 = 1'b1; tick(); sync1 = 1'b0; tick();
    n_cmp++;
    if (obs1 !== {ST_IDLE, 3'b000, 4'h0}) begin
      n_bad++; $display("FAIL f1_idle_sync: got %h want %h", obs1, {ST_IDLE, 3'b000, 4'h0});
    end
    req1 = 2'b10;
    tick();
    n_cmp++;
    if (obs1 !== {ST_SEND, 3'b110, 2'b10, 2'b00} || {enc_a1, enc_d1} !== 12'hC39) begin
      n_bad++; $display("FAIL f1_grant: got %h/%h want %h/c39", obs1, {enc_a1, enc_d1}, {ST_SEND, 3'b110, 2'b10, 2'b00});
    end
    sync1 = 1'b1;
    tick();
    req1 = 2'b00;
    n_cmp++;
    if (obs1 !== {ST_DONE, 3'b100, 2'b00, 2'b10}) begin
      n_bad++; $display("FAIL f1_done: got %h want %h", obs1, {ST_DONE, 3'b100, 2'b00, 2'b10});
    end
    sync1 = 1'b0;
    tick();
    n_cmp++;
    if (obs1 !== {ST_IDLE, 3'b000, 4'h0}) begin
      n_bad++; $display("FAIL f1_idle: got %h want %h", obs1, {ST_IDLE, 3'b000, 4'h0});
    end
  endtask

`ifdef PT2262_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (99) tick();
    n_cmp++;
    if (obs !== {ST_SEND, 3'b110, 4'b0001, 4'b0000}) begin
      n_bad++; $display("FAIL wd_pre: got %h want %h", obs, {ST_SEND, 3'b110, 4'b0001, 4'b0000});
    end
    tick();
    n_cmp++;
    if (obs !== {ST_DONE, 3'b101, 8'h00}) begin
      n_bad++; $display("FAIL wd_abort: got %h want %h", obs, {ST_DONE, 3'b101, 8'h00});
    end
    tick();
    n_cmp++;
    if (obs !== {ST_IDLE, 3'b000, 8'h00}) begin
      n_bad++; $display("FAIL wd_idle: got %h want %h", obs, {ST_IDLE, 3'b000, 8'h00});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_frame1();
`ifdef PT2262_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
